// File: rtl/wb_slave_load_sequencer_if.sv
// Wishbone write-side bundle between the load sequencer (master) and the
// Theia core's WB slave unit.
interface wb_slave_load_sequencer_if #(
   parameter int WB_WIDTH = 32
) ();

   logic                CYC_O;
   logic                STB_O;
   logic                WE_O;
   logic                MST_O;
   logic [WB_WIDTH-1:0] ADR_O;
   logic [1:0]          TGA_O;
   logic [WB_WIDTH-1:0] DAT_O;
   logic                ACK_I;

   modport master (
      output CYC_O, STB_O, WE_O, MST_O, ADR_O, TGA_O, DAT_O,
      input  ACK_I
   );

   modport slave (
      input  CYC_O, STB_O, WE_O, MST_O, ADR_O, TGA_O, DAT_O,
      output ACK_I
   );

endinterface

// File: rtl/wb_slave_load_sequencer.sv
// Round-robin write sequencer that loads data rows (X/Y/Z) and instructions
// (X/Y) into a Theia WB slave, finishing each transfer with an MST-high/CYC-low commit.
module wb_slave_load_sequencer #(
   parameter int WB_WIDTH    = 32,
   parameter int ACK_TIMEOUT = 255
) (
   input  logic        CLK_I,
   input  logic        RST_I,
   input  logic        iReqValid0,
   input  logic        iReqValid1,
   input  logic        iReqIsInstr0,
   input  logic        iReqIsInstr1,
   input  logic [15:0] iReqAddress0,
   input  logic [15:0] iReqAddress1,
   input  logic [95:0] iReqData0,
   input  logic [95:0] iReqData1,
   output logic        oGrant0,
   output logic        oGrant1,
   output logic        oDone0,
   output logic        oDone1,
   output logic        oError0,
   output logic        oError1,
   wb_slave_load_sequencer_if.master wb
);

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      STROBE,
      GAP,
      COMMIT,
      ABORT
   } state_t;

   localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

   state_t      state, next_state;
   logic [1:0]  word_q, word_d;
   logic [7:0]  tmo_q, tmo_d;
   logic        owner_q;
   logic        last_grant_q;
   logic        is_instr_q;
   logic [15:0] addr_q;
   logic [95:0] data_q;
   logic        grant_any;
   logic        grant_sel;
   logic [1:0]  last_word;
   logic [1:0]  dat_sel;
   logic [31:0] cur_word;
   logic [1:0]  cur_tga;

   assign last_word = is_instr_q ? 2'd1 : 2'd2;
   assign cur_tga   = is_instr_q ? 2'b10 : 2'b01;

   // An ACK landing in the last allowed STROBE cycle is taken before the timeout check.
   always_comb begin
      next_state = state;
      word_d     = word_q;
      tmo_d      = tmo_q;
      grant_any  = 1'b0;
      grant_sel  = 1'b0;
      case (state)
         IDLE: begin
            if (RST_I && (iReqValid0 || iReqValid1)) begin
               grant_any  = 1'b1;
               grant_sel  = (iReqValid0 && iReqValid1) ? ~last_grant_q : iReqValid1;
               word_d     = 2'd0;
               next_state = SETUP;
            end
         end
         SETUP: begin
            tmo_d      = 8'd0;
            next_state = STROBE;
         end
         STROBE: begin
            if (wb.ACK_I) begin
               if (word_q == last_word) begin
                  next_state = COMMIT;
               end else begin
                  word_d     = word_q + 2'd1;
                  next_state = GAP;
               end
            end else if (tmo_q == TMO_LAST) begin
               next_state = ABORT;
            end else begin
               tmo_d = tmo_q + 8'd1;
            end
         end
         GAP: begin
            tmo_d      = 8'd0;
            next_state = STROBE;
         end
         COMMIT:  next_state = IDLE;
         ABORT:   next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge CLK_I or negedge RST_I) begin
      if (!RST_I) begin
         state        <= IDLE;
         word_q       <= 2'd0;
         tmo_q        <= 8'd0;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         is_instr_q   <= 1'b0;
         addr_q       <= 16'd0;
         data_q       <= 96'd0;
      end else begin
         state  <= next_state;
         word_q <= word_d;
         tmo_q  <= tmo_d;
         if (grant_any) begin
            owner_q      <= grant_sel;
            last_grant_q <= grant_sel;
            is_instr_q   <= grant_sel ? iReqIsInstr1 : iReqIsInstr0;
            addr_q       <= grant_sel ? iReqAddress1 : iReqAddress0;
            data_q       <= grant_sel ? iReqData1    : iReqData0;
         end
      end
   end

   // The word index already points past the acknowledged word during GAP, so step back one to hold DAT_O.
   always_comb begin
      dat_sel = (state == GAP) ? (word_q - 2'd1) : word_q;
      case (dat_sel)
         2'd0:    cur_word = data_q[95:64];
         2'd1:    cur_word = data_q[63:32];
         default: cur_word = data_q[31:0];
      endcase
   end

   always_comb begin
      wb.CYC_O = 1'b0;
      wb.STB_O = 1'b0;
      wb.WE_O  = 1'b0;
      wb.MST_O = 1'b0;
      wb.ADR_O = '0;
      wb.TGA_O = 2'b00;
      wb.DAT_O = '0;
      case (state)
         SETUP, COMMIT: begin
            wb.WE_O  = 1'b1;
            wb.MST_O = 1'b1;
            wb.ADR_O = WB_WIDTH'(addr_q);
            wb.TGA_O = cur_tga;
         end
         STROBE, GAP: begin
            wb.CYC_O = 1'b1;
            wb.STB_O = (state == STROBE);
            wb.WE_O  = 1'b1;
            wb.MST_O = 1'b1;
            wb.ADR_O = WB_WIDTH'(addr_q);
            wb.TGA_O = cur_tga;
            wb.DAT_O = WB_WIDTH'(cur_word);
         end
         default: ;
      endcase
   end

   assign oGrant0 = grant_any && !grant_sel;
   assign oGrant1 = grant_any &&  grant_sel;
   assign oDone0  = (state == COMMIT) && !owner_q;
   assign oDone1  = (state == COMMIT) &&  owner_q;
   assign oError0 = (state == ABORT)  && !owner_q;
   assign oError1 = (state == ABORT)  &&  owner_q;

endmodule

// File: tb/tb_wb_slave_load_sequencer.sv
// Scoreboard bench for wb_slave_load_sequencer: expected words are queued when a
// request is driven and matched against words the slave model sees acknowledged.
module tb_wb_slave_load_sequencer;

   logic        CLK_I = 1'b0;
   logic        RST_I = 1'b0;
   logic        iReqValid0 = 1'b0, iReqValid1 = 1'b0;
   logic        iReqIsInstr0 = 1'b0, iReqIsInstr1 = 1'b0;
   logic [15:0] iReqAddress0 = 16'd0, iReqAddress1 = 16'd0;
   logic [95:0] iReqData0 = 96'd0, iReqData1 = 96'd0;
   logic        oGrant0, oGrant1, oDone0, oDone1, oError0, oError1;

   wb_slave_load_sequencer_if #(.WB_WIDTH(32)) bus ();

   wb_slave_load_sequencer #(.WB_WIDTH(32), .ACK_TIMEOUT(4)) dut (
      .CLK_I        (CLK_I),
      .RST_I        (RST_I),
      .iReqValid0   (iReqValid0),
      .iReqValid1   (iReqValid1),
      .iReqIsInstr0 (iReqIsInstr0),
      .iReqIsInstr1 (iReqIsInstr1),
      .iReqAddress0 (iReqAddress0),
      .iReqAddress1 (iReqAddress1),
      .iReqData0    (iReqData0),
      .iReqData1    (iReqData1),
      .oGrant0      (oGrant0),
      .oGrant1      (oGrant1),
      .oDone0       (oDone0),
      .oDone1       (oDone1),
      .oError0      (oError0),
      .oError1      (oError1),
      .wb           (bus.master)
   );

   int          vectors = 0;
   int          miscompares = 0;
   int          ack_delay = 1;
   bit          ack_force = 1'b0;
   logic [31:0] exp_q[$];
   logic [31:0] got_q[$];
   logic [31:0] e, g;

   int          obs_end, obs_kind, obs_owner, obs_grants, obs_stb;
   logic [3:0]  obs_ctl;
   logic [31:0] obs_adr;
   logic [1:0]  obs_tga;

   localparam logic [95:0] DATA_A = {32'h11111111, 32'h22222222, 32'h33333333};
   localparam logic [95:0] DATA_B = {32'hA5A5A5A5, 32'h5A5A5A5A, 32'hDEADBEEF};
   localparam logic [95:0] DATA_C = {32'hCAFEF00D, 32'h0BADC0DE, 32'h76543210};

   initial begin
      forever #5 CLK_I = ~CLK_I;
   end

   // Slave model: ACK rises in the (ack_delay+1)-th cycle of each strobe, or stays high when forced.
   initial begin
      int stb_cnt;
      stb_cnt   = 0;
      bus.ACK_I = 1'b0;
      forever begin
         @(posedge CLK_I);
         #1;
         if (!RST_I) begin
            stb_cnt   = 0;
            bus.ACK_I = 1'b0;
         end else if (bus.STB_O) begin
            stb_cnt++;
            bus.ACK_I = ack_force || (stb_cnt == ack_delay + 1);
         end else begin
            stb_cnt   = 0;
            bus.ACK_I = ack_force;
         end
      end
   end

   task automatic set_req(input int who, input bit valid, input bit instr,
                          input logic [15:0] addr, input logic [95:0] data);
      if (who == 0) begin
         iReqValid0 = valid; iReqIsInstr0 = instr; iReqAddress0 = addr; iReqData0 = data;
      end else begin
         iReqValid1 = valid; iReqIsInstr1 = instr; iReqAddress1 = addr; iReqData1 = data;
      end
   endtask

   task automatic push_words(input logic [95:0] data, input bit instr);
      exp_q.push_back(data[95:64]);
      exp_q.push_back(data[63:32]);
      if (!instr) exp_q.push_back(data[31:0]);
   endtask

   task automatic reset_dut();
      RST_I     = 1'b0;
      ack_force = 1'b0;
      ack_delay = 1;
      repeat (2) @(negedge CLK_I);
      RST_I = 1'b1;
      exp_q.delete();
      got_q.delete();
   endtask

   // Collects what the bus does from cycle 'first' until the transfer ends or 'last' expires.
   task automatic observe(input int first, input int last);
      obs_end = -1; obs_kind = 0; obs_owner = -1; obs_grants = 0; obs_stb = 0;
      obs_ctl = 4'h0; obs_adr = 32'h0; obs_tga = 2'b00;
      for (int c = first; c <= last; c++) begin
         @(negedge CLK_I);
         if (bus.STB_O) obs_stb++;
         if (bus.STB_O && bus.ACK_I) got_q.push_back(bus.DAT_O);
         if (oGrant0 || oGrant1) obs_grants++;
         if (oDone0 || oDone1 || oError0 || oError1) begin
            obs_end   = c;
            obs_kind  = (oDone0 || oDone1) ? 1 : 2;
            obs_owner = (oDone1 || oError1) ? 1 : 0;
            obs_ctl   = {bus.CYC_O, bus.STB_O, bus.WE_O, bus.MST_O};
            obs_adr   = bus.ADR_O;
            obs_tga   = bus.TGA_O;
            break;
         end
      end
   endtask

   task automatic test_reset();
      #1;
      vectors++; if ({bus.CYC_O, bus.STB_O, bus.WE_O, bus.MST_O} !== 4'b0000) begin miscompares++; $display("[TB] FAIL reset_ctl: got %b expected 0000", {bus.CYC_O, bus.STB_O, bus.WE_O, bus.MST_O}); end
      vectors++; if ({bus.ADR_O, bus.DAT_O, bus.TGA_O} !== 66'd0) begin miscompares++; $display("[TB] FAIL reset_bus: got adr %0h dat %0h tga %b expected 0", bus.ADR_O, bus.DAT_O, bus.TGA_O); end
      iReqValid0 = 1'b1;
      #1;
      vectors++; if ({oGrant0, oGrant1, oDone0, oDone1, oError0, oError1} !== 6'd0) begin miscompares++; $display("[TB] FAIL reset_pulses: got %b expected 000000", {oGrant0, oGrant1, oDone0, oDone1, oError0, oError1}); end
      iReqValid0 = 1'b0;
      reset_dut();
   endtask

   task automatic test_data_write();
      reset_dut();
      push_words(DATA_A, 1'b0);
      set_req(0, 1'b1, 1'b0, 16'h0012, DATA_A);
      #1;
      vectors++; if ({oGrant0, oGrant1} !== 2'b10) begin miscompares++; $display("[TB] FAIL data_grant: got %b expected 10", {oGrant0, oGrant1}); end
      @(posedge CLK_I); #1;
      set_req(0, 1'b0, 1'b0, 16'h0, 96'd0);
      @(negedge CLK_I);
      vectors++; if ({bus.CYC_O, bus.STB_O, bus.WE_O, bus.MST_O, bus.ADR_O, bus.TGA_O} !== {4'b0011, 32'h12, 2'b01}) begin miscompares++; $display("[TB] FAIL data_setup: got ctl %b adr %0h tga %b expected 0011/12/01", {bus.CYC_O, bus.STB_O, bus.WE_O, bus.MST_O}, bus.ADR_O, bus.TGA_O); end
      observe(2, 30);
      vectors++; if (obs_end !== 10 || obs_kind !== 1 || obs_owner !== 0) begin miscompares++; $display("[TB] FAIL data_commit: got cycle %0d kind %0d owner %0d expected 10/1/0", obs_end, obs_kind, obs_owner); end
      vectors++; if ({obs_ctl, obs_adr, obs_tga} !== {4'b0011, 32'h12, 2'b01}) begin miscompares++; $display("[TB] FAIL data_commit_bus: got ctl %b adr %0h tga %b expected 0011/12/01", obs_ctl, obs_adr, obs_tga); end
      vectors++; if (got_q.size() !== exp_q.size()) begin miscompares++; $display("[TB] FAIL data_word_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front();
         vectors++; if (g !== e) begin miscompares++; $display("[TB] FAIL data_word: got %h expected %h", g, e); end
      end
      @(negedge CLK_I);
      vectors++; if ({oDone0, bus.CYC_O, bus.MST_O, bus.TGA_O} !== 5'b0) begin miscompares++; $display("[TB] FAIL data_after_commit: got %b expected 00000", {oDone0, bus.CYC_O, bus.MST_O, bus.TGA_O}); end
   endtask

   task automatic test_instr_write();
      reset_dut();
      push_words(DATA_B, 1'b1);
      set_req(1, 1'b1, 1'b1, 16'h0040, DATA_B);
      #1;
      vectors++; if ({oGrant0, oGrant1} !== 2'b01) begin miscompares++; $display("[TB] FAIL instr_grant: got %b expected 01", {oGrant0, oGrant1}); end
      @(posedge CLK_I); #1;
      set_req(1, 1'b0, 1'b0, 16'h0, 96'd0);
      observe(1, 30);
      vectors++; if (obs_end !== 7 || obs_kind !== 1 || obs_owner !== 1) begin miscompares++; $display("[TB] FAIL instr_commit: got cycle %0d kind %0d owner %0d expected 7/1/1", obs_end, obs_kind, obs_owner); end
      vectors++; if ({obs_ctl, obs_adr, obs_tga} !== {4'b0011, 32'h40, 2'b10}) begin miscompares++; $display("[TB] FAIL instr_commit_bus: got ctl %b adr %0h tga %b expected 0011/40/10", obs_ctl, obs_adr, obs_tga); end
      vectors++; if (got_q.size() !== exp_q.size()) begin miscompares++; $display("[TB] FAIL instr_word_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front();
         vectors++; if (g !== e) begin miscompares++; $display("[TB] FAIL instr_word: got %h expected %h", g, e); end
      end
   endtask

   task automatic test_back_to_back();
      int gcyc[$];
      int gown[$];
      int dones;
      dones = 0;
      set_req(0, 1'b1, 1'b0, 16'h0100, DATA_A);
      set_req(1, 1'b1, 1'b0, 16'h0200, DATA_C);
      reset_dut();
      for (int i = 0; i < 4; i++) push_words((i % 2 == 0) ? DATA_A : DATA_C, 1'b0);
      for (int c = 0; c < 60 && dones < 4; c++) begin
         if (c > 0) @(negedge CLK_I);
         #1;
         if (bus.STB_O && bus.ACK_I) got_q.push_back(bus.DAT_O);
         if (oGrant0 || oGrant1) begin gcyc.push_back(c); gown.push_back(oGrant1 ? 1 : 0); end
         if (oDone0 || oDone1) dones++;
      end
      set_req(0, 1'b0, 1'b0, 16'h0, 96'd0);
      set_req(1, 1'b0, 1'b0, 16'h0, 96'd0);
      vectors++; if (dones !== 4 || gcyc.size() !== 4) begin miscompares++; $display("[TB] FAIL b2b_counts: got dones %0d grants %0d expected 4/4", dones, gcyc.size()); end
      for (int i = 0; i < 4 && i < gcyc.size(); i++) begin
         vectors++; if (gcyc[i] !== 11 * i || gown[i] !== i % 2) begin miscompares++; $display("[TB] FAIL b2b_grant%0d: got cycle %0d owner %0d expected %0d/%0d", i, gcyc[i], gown[i], 11 * i, i % 2); end
      end
      vectors++; if (got_q.size() !== exp_q.size()) begin miscompares++; $display("[TB] FAIL b2b_word_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front();
         vectors++; if (g !== e) begin miscompares++; $display("[TB] FAIL b2b_word: got %h expected %h", g, e); end
      end
      @(negedge CLK_I);
   endtask

   task automatic test_timeout();
      reset_dut();
      ack_delay = 100;
      set_req(0, 1'b1, 1'b0, 16'h0007, DATA_B);
      #1;
      @(posedge CLK_I); #1;
      set_req(0, 1'b0, 1'b0, 16'h0, 96'd0);
      observe(1, 30);
      vectors++; if (obs_end !== 6 || obs_kind !== 2 || obs_owner !== 0) begin miscompares++; $display("[TB] FAIL abort_cycle: got cycle %0d kind %0d owner %0d expected 6/2/0", obs_end, obs_kind, obs_owner); end
      vectors++; if ({obs_ctl, obs_adr, obs_tga} !== 38'd0) begin miscompares++; $display("[TB] FAIL abort_bus: got ctl %b adr %0h tga %b expected all 0", obs_ctl, obs_adr, obs_tga); end
      vectors++; if (obs_stb !== 4 || got_q.size() !== 0) begin miscompares++; $display("[TB] FAIL abort_strobe: got %0d strobe cycles %0d words expected 4/0", obs_stb, got_q.size()); end
      // ACK on the fourth strobe cycle must win over the timeout.
      @(negedge CLK_I);
      ack_delay = 3;
      push_words(DATA_C, 1'b0);
      set_req(0, 1'b1, 1'b0, 16'h0008, DATA_C);
      @(posedge CLK_I); #1;
      set_req(0, 1'b0, 1'b0, 16'h0, 96'd0);
      observe(1, 40);
      vectors++; if (obs_end !== 16 || obs_kind !== 1 || obs_stb !== 12) begin miscompares++; $display("[TB] FAIL ack_at_limit: got cycle %0d kind %0d strobes %0d expected 16/1/12", obs_end, obs_kind, obs_stb); end
      vectors++; if (got_q.size() !== exp_q.size()) begin miscompares++; $display("[TB] FAIL ack_at_limit_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front();
         vectors++; if (g !== e) begin miscompares++; $display("[TB] FAIL ack_at_limit_word: got %h expected %h", g, e); end
      end
   endtask

   task automatic test_reset_mid_transfer();
      reset_dut();
      set_req(0, 1'b1, 1'b0, 16'h0033, DATA_A);
      repeat (5) @(negedge CLK_I);
      vectors++; if ({bus.STB_O, bus.DAT_O} !== {1'b1, DATA_A[63:32]}) begin miscompares++; $display("[TB] FAIL mid_y_strobe: got stb %b dat %h expected 1/%h", bus.STB_O, bus.DAT_O, DATA_A[63:32]); end
      #2 RST_I = 1'b0;
      #1;
      vectors++; if ({bus.CYC_O, bus.STB_O, bus.WE_O, bus.MST_O, bus.ADR_O, bus.DAT_O, bus.TGA_O} !== 70'd0) begin miscompares++; $display("[TB] FAIL mid_reset_bus: got ctl %b adr %0h dat %0h expected 0", {bus.CYC_O, bus.STB_O, bus.WE_O, bus.MST_O}, bus.ADR_O, bus.DAT_O); end
      vectors++; if ({oGrant0, oDone0, oError0} !== 3'b000) begin miscompares++; $display("[TB] FAIL mid_reset_pulses: got %b expected 000", {oGrant0, oDone0, oError0}); end
      repeat (2) @(negedge CLK_I);
      RST_I = 1'b1;
      got_q.delete();
      push_words(DATA_A, 1'b0);
      #1;
      vectors++; if (oGrant0 !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_regrant: got %b expected 1", oGrant0); end
      @(posedge CLK_I); #1;
      set_req(0, 1'b0, 1'b0, 16'h0, 96'd0);
      observe(1, 30);
      vectors++; if (obs_end !== 10 || obs_kind !== 1 || obs_grants !== 0) begin miscompares++; $display("[TB] FAIL mid_redo_commit: got cycle %0d kind %0d grants %0d expected 10/1/0", obs_end, obs_kind, obs_grants); end
      vectors++; if (got_q.size() !== exp_q.size()) begin miscompares++; $display("[TB] FAIL mid_redo_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front();
         vectors++; if (g !== e) begin miscompares++; $display("[TB] FAIL mid_redo_word: got %h expected %h", g, e); end
      end
   endtask

   task automatic test_ack_outside_strobe();
      reset_dut();
      ack_force = 1'b1;
      repeat (3) @(negedge CLK_I);
      #1;
      vectors++; if ({bus.CYC_O, bus.MST_O, oGrant0, oGrant1, oDone0, oError0} !== 6'd0) begin miscompares++; $display("[TB] FAIL idle_ack: got %b expected 000000", {bus.CYC_O, bus.MST_O, oGrant0, oGrant1, oDone0, oError0}); end
      push_words(DATA_B, 1'b0);
      set_req(0, 1'b1, 1'b0, 16'h0055, DATA_B);
      @(posedge CLK_I); #1;
      set_req(0, 1'b0, 1'b0, 16'h0, 96'd0);
      observe(1, 30);
      vectors++; if (obs_end !== 7 || obs_kind !== 1 || obs_stb !== 3) begin miscompares++; $display("[TB] FAIL ack_held_commit: got cycle %0d kind %0d strobes %0d expected 7/1/3", obs_end, obs_kind, obs_stb); end
      vectors++; if (got_q.size() !== exp_q.size()) begin miscompares++; $display("[TB] FAIL ack_held_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         e = exp_q.pop_front(); g = got_q.pop_front();
         vectors++; if (g !== e) begin miscompares++; $display("[TB] FAIL ack_held_word: got %h expected %h", g, e); end
      end
      ack_force = 1'b0;
   endtask

   initial begin
      test_reset();
      test_data_write();
      test_instr_write();
      test_back_to_back();
      test_timeout();
      test_reset_mid_transfer();
      test_ack_outside_strobe();
      repeat (2) @(negedge CLK_I);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
